// File: rtl/lane_byte_align_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : lane_byte_align_if                                           |
// | Purpose   : Bundles the lane-aligner datapath and status signals.        |
// |             Lane 0 is the earliest octet in time within a word.          |
// | Signals   : cdr_ready    - transceiver lock (driver -> aligner)          |
// |             resync       - request to drop alignment (driver -> aligner) |
// |             in_data/in_k - deserialized octets and K flags, 4 lanes      |
// |             out_data/out_k - realigned octets and K flags, 4 lanes       |
// |             aligned      - high while locked                             |
// |             align_offset - current byte rotation                         |
// |             align_fault  - sticky realignment-fault flag                 |
// | Modports  : master (stimulus side), slave (lane_byte_align)              |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
interface lane_byte_align_if;
  logic            cdr_ready;
  logic            resync;
  logic [3:0][7:0] in_data;
  logic [3:0]      in_k;
  logic [3:0][7:0] out_data;
  logic [3:0]      out_k;
  logic            aligned;
  logic [1:0]      align_offset;
  logic            align_fault;

  modport master (
    output cdr_ready, resync, in_data, in_k,
    input  out_data, out_k, aligned, align_offset, align_fault
  );

  modport slave (
    input  cdr_ready, resync, in_data, in_k,
    output out_data, out_k, aligned, align_offset, align_fault
  );
endinterface
`default_nettype wire

// File: rtl/lane_byte_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : lane_byte_align                                              |
// | Purpose   : 4-lane byte aligner. Finds code-group sync on /K/ (K28.5),   |
// |             locks the byte rotation on the first /R/ (K28.0) and         |
// |             monitors /A/ (K28.3) and /F/ (K28.7) placement, realigning   |
// |             after FAULT_LIMIT consecutive misplaced characters.          |
// | Ports     : clk          - rising-edge clock                             |
// |             rst_n        - asynchronous active-low reset                 |
// |             bus (slave)  - cdr_ready, resync, in_data/in_k inputs;       |
// |                            out_data/out_k, aligned, align_offset,        |
// |                            align_fault registered outputs                |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module lane_byte_align #(
  parameter int CGS_COUNT   = 4,
  parameter int FAULT_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  lane_byte_align_if.slave  bus
);

  localparam int         CGS_W = $clog2(CGS_COUNT + 1);
  localparam int         FLT_W = $clog2(FAULT_LIMIT + 1);
  localparam logic [7:0] K28_5 = 8'hBC;  // /K/
  localparam logic [7:0] K28_0 = 8'h1C;  // /R/
  localparam logic [7:0] K28_3 = 8'h7C;  // /A/
  localparam logic [7:0] K28_7 = 8'hFC;  // /F/

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CGS    = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  state_t           state;
  logic [CGS_W-1:0] cgs_cnt;
  logic [FLT_W-1:0] flt_cnt;
  logic [1:0]       offset;
  logic             aligned_r;
  logic             fault_r;

  logic [3:0][7:0]  hist_data;
  logic [3:0]       hist_k;
  logic [3:0][7:0]  out_data_r;
  logic [3:0]       out_k_r;

  // Eight-entry stream: history in entries 0..3, current word in 4..7.
  logic [7:0][7:0]  s_data;
  logic [7:0]       s_k;
  logic [3:0][7:0]  nxt_data;
  logic [3:0]       nxt_k;

  logic             all_cgs;
  logic [3:0]       is_r;
  logic             any_data;
  logic [1:0]       r_lane;
  logic             out_misplaced;
  logic             out_good;
  logic [CGS_W-1:0] cgs_inc;
  logic [FLT_W-1:0] flt_inc;

  assign s_data = {bus.in_data, hist_data};
  assign s_k    = {bus.in_k, hist_k};

  // Output lane j takes stream entry offset+j; never gated by state.
  always_comb begin
    nxt_data = '0;
    nxt_k    = '0;
    for (int j = 0; j < 4; j++) begin
      nxt_data[j] = s_data[3'(j) + {1'b0, offset}];
      nxt_k[j]    = s_k[3'(j) + {1'b0, offset}];
    end
  end

  // Input-word classification and output-word /A/,/F/ placement check.
  always_comb begin
    all_cgs       = 1'b1;
    is_r          = '0;
    any_data      = 1'b0;
    r_lane        = 2'd0;
    out_misplaced = 1'b0;
    out_good      = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!(bus.in_k[i] && (bus.in_data[i] == K28_5))) all_cgs = 1'b0;
      if (!bus.in_k[i]) any_data = 1'b1;
      is_r[i] = bus.in_k[i] && (bus.in_data[i] == K28_0);
    end
    // Descending scan so the lowest matching lane wins.
    for (int i = 3; i >= 0; i--) begin
      if (is_r[i]) r_lane = 2'(i);
    end
    for (int i = 0; i < 3; i++) begin
      if (out_k_r[i] && ((out_data_r[i] == K28_3) || (out_data_r[i] == K28_7)))
        out_misplaced = 1'b1;
    end
    out_good = out_k_r[3] && ((out_data_r[3] == K28_3) || (out_data_r[3] == K28_7));
  end

  // Saturating increments.
  assign cgs_inc = (cgs_cnt == CGS_W'(CGS_COUNT))   ? cgs_cnt : cgs_cnt + 1'b1;
  assign flt_inc = (flt_cnt == FLT_W'(FAULT_LIMIT)) ? flt_cnt : flt_cnt + 1'b1;

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_data  <= '0;
      hist_k     <= '0;
      out_data_r <= '0;
      out_k_r    <= '0;
    end else begin
      hist_data  <= bus.in_data;
      hist_k     <= bus.in_k;
      out_data_r <= nxt_data;
      out_k_r    <= nxt_k;
    end
  end

  // Alignment FSM with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cgs_cnt   <= '0;
      flt_cnt   <= '0;
      offset    <= 2'd0;
      aligned_r <= 1'b0;
      fault_r   <= 1'b0;
    end else if (bus.resync || !bus.cdr_ready) begin
      // Resync outranks every other transition, including a fault this cycle.
      state     <= ST_IDLE;
      cgs_cnt   <= '0;
      flt_cnt   <= '0;
      offset    <= 2'd0;
      aligned_r <= 1'b0;
      if (bus.resync) fault_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          offset  <= 2'd0;
          cgs_cnt <= '0;
          state   <= ST_CGS;
        end
        ST_CGS: begin
          if (all_cgs) begin
            if (cgs_inc == CGS_W'(CGS_COUNT)) begin
              state   <= ST_WAIT_R;
              cgs_cnt <= '0;
            end else begin
              cgs_cnt <= cgs_inc;
            end
          end else begin
            cgs_cnt <= '0;
          end
        end
        ST_WAIT_R: begin
          if (|is_r) begin
            offset    <= r_lane;
            flt_cnt   <= '0;
            aligned_r <= 1'b1;
            state     <= ST_LOCKED;
          end else if (any_data) begin
            cgs_cnt <= '0;
            state   <= ST_CGS;
          end
        end
        ST_LOCKED: begin
          if (out_misplaced) begin
            if (flt_inc == FLT_W'(FAULT_LIMIT)) begin
              fault_r   <= 1'b1;
              flt_cnt   <= '0;
              offset    <= 2'd0;
              cgs_cnt   <= '0;
              aligned_r <= 1'b0;
              state     <= ST_CGS;
            end else begin
              flt_cnt <= flt_inc;
            end
          end else if (out_good) begin
            flt_cnt <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_data     = out_data_r;
  assign bus.out_k        = out_k_r;
  assign bus.aligned      = aligned_r;
  assign bus.align_offset = offset;
  assign bus.align_fault  = fault_r;

endmodule
`default_nettype wire

// File: tb/tb_lane_byte_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_lane_byte_align                                           |
// | Purpose   : Self-checking bench for lane_byte_align: directed sequences  |
// |             followed by randomized framing, all compared against a       |
// |             byte-stream reference model.                                 |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module tb_lane_byte_align;

  logic clk = 1'b0;
  logic rst_n;

  lane_byte_align_if bus ();

  lane_byte_align #(.CGS_COUNT(4), .FAULT_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus word for the next cycle.
  logic [7:0] wd[4];
  logic       wk[4];
  logic       cdr;
  logic       rs;

  // Reference model: state as plain integers, data as a byte stream.
  localparam int M_IDLE = 0, M_CGS = 1, M_WAITR = 2, M_LOCKED = 3;
  int         m_st;
  int         m_cc;
  int         m_fc;
  int         m_r;
  bit         m_flt;
  logic [8:0] m_out[4];
  logic [8:0] strm[$];

  function automatic bit is_af(input logic [8:0] v);
    return v[8] && ((v[7:0] == 8'h7C) || (v[7:0] == 8'hFC));
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_cc = 0; m_fc = 0; m_r = 0; m_flt = 1'b0;
    for (int j = 0; j < 4; j++) m_out[j] = '0;
    strm.delete();
    for (int j = 0; j < 4; j++) strm.push_back(9'h000);
  endtask

  task automatic model_step();
    logic [8:0] nxt[4];
    bit allk, anydk, mis, good;
    int rl;
    // Stream holds the previous word then the current word (oldest first).
    for (int i = 0; i < 4; i++) strm.push_back({wk[i], wd[i]});
    while (strm.size() > 8) void'(strm.pop_front());
    for (int j = 0; j < 4; j++) nxt[j] = strm[m_r + j];

    allk = 1'b1; anydk = 1'b0; rl = -1;
    for (int i = 0; i < 4; i++) begin
      if (!(wk[i] && wd[i] == 8'hBC)) allk = 1'b0;
      if (!wk[i]) anydk = 1'b1;
      if (rl < 0 && wk[i] && wd[i] == 8'h1C) rl = i;
    end
    mis = is_af(m_out[0]) || is_af(m_out[1]) || is_af(m_out[2]);
    good = is_af(m_out[3]);

    if (rs || !cdr) begin
      m_st = M_IDLE; m_cc = 0; m_fc = 0; m_r = 0;
      if (rs) m_flt = 1'b0;
    end else begin
      case (m_st)
        M_IDLE: begin m_st = M_CGS; m_cc = 0; m_r = 0; end
        M_CGS: begin
          if (allk) begin
            m_cc++;
            if (m_cc >= 4) begin m_st = M_WAITR; m_cc = 0; end
          end else m_cc = 0;
        end
        M_WAITR: begin
          if (rl >= 0) begin m_r = rl; m_st = M_LOCKED; m_fc = 0; end
          else if (anydk) begin m_st = M_CGS; m_cc = 0; end
        end
        default: begin
          if (mis) begin
            m_fc++;
            if (m_fc >= 4) begin
              m_flt = 1'b1; m_fc = 0; m_r = 0; m_cc = 0; m_st = M_CGS;
            end
          end else if (good) m_fc = 0;
        end
      endcase
    end
    for (int j = 0; j < 4; j++) m_out[j] = nxt[j];
  endtask

  task automatic compare_all();
    check("aligned", bus.aligned, (m_st == M_LOCKED));
    check("offset", bus.align_offset, m_r);
    check("fault", bus.align_fault, m_flt);
    for (int j = 0; j < 4; j++)
      check($sformatf("out_lane%0d", j), {bus.out_k[j], bus.out_data[j]}, m_out[j]);
  endtask

  task automatic step();
    bus.cdr_ready = cdr;
    bus.resync    = rs;
    for (int i = 0; i < 4; i++) begin
      bus.in_data[i] = wd[i];
      bus.in_k[i]    = wk[i];
    end
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Word builders.
  task automatic w_cgs();
    for (int i = 0; i < 4; i++) begin wd[i] = 8'hBC; wk[i] = 1'b1; end
  endtask

  task automatic w_data();
    for (int i = 0; i < 4; i++) begin wd[i] = 8'($urandom); wk[i] = 1'b0; end
  endtask

  task automatic w_r(input int lane);
    w_data();
    for (int i = 0; i < lane; i++) begin wd[i] = 8'hBC; wk[i] = 1'b1; end
    wd[lane] = 8'h1C; wk[lane] = 1'b1;
  endtask

  task automatic w_char(input int lane, input logic [7:0] ch);
    w_data();
    wd[lane] = ch; wk[lane] = 1'b1;
  endtask

  task automatic w_wild();
    for (int i = 0; i < 4; i++) begin
      wk[i] = 1'($urandom);
      case ($urandom_range(0, 4))
        0: wd[i] = 8'hBC;
        1: wd[i] = 8'h1C;
        2: wd[i] = 8'h7C;
        3: wd[i] = 8'hFC;
        default: wd[i] = 8'($urandom);
      endcase
    end
  endtask

  task automatic lock(input int lane);
    cdr = 1'b1; rs = 1'b0;
    w_data(); step();
    repeat (4) begin w_cgs(); step(); end
    w_r(lane); step();
  endtask

  task automatic rand_ctrl();
    cdr = ($urandom_range(0, 99) != 0);
    rs  = ($urandom_range(0, 99) == 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; cdr = 1'b0; rs = 1'b0;
    for (int i = 0; i < 4; i++) begin wd[i] = 8'h00; wk[i] = 1'b0; end
    bus.cdr_ready = 1'b0; bus.resync = 1'b0; bus.in_data = '0; bus.in_k = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", {bus.out_k, bus.out_data}, 36'h0);
    check("rst_aligned", bus.aligned, 0);
    check("rst_offset", bus.align_offset, 0);
    check("rst_fault", bus.align_fault, 0);
    rst_n = 1'b1;
    model_reset();

    // Lock with /R/ in lane 2; /R/ reaches output lane 0 one edge later.
    lock(2);
    check("r034_offset", bus.align_offset, 2);
    check("r034_aligned", bus.aligned, 1);
    w_data(); step();
    check("r034_out0", {bus.out_k[0], bus.out_data[0]}, 9'h11C);

    // r=2: input lane 0 lands on output lane 2, input lane 1 on output lane 3.
    repeat (3) begin w_char(0, 8'hFC); step(); end
    w_char(1, 8'hFC); step();
    repeat (3) begin w_char(0, 8'hFC); step(); end
    repeat (3) begin w_data(); step(); end
    check("r037_nofault", bus.align_fault, 0);
    check("r037_aligned", bus.aligned, 1);

    // Resync, relock at r=1, then /A/ on output lane 1 (input lane 2).
    rs = 1'b1; w_data(); step(); rs = 1'b0;
    lock(1);
    repeat (4) begin w_char(2, 8'h7C); step(); end
    repeat (3) begin w_data(); step(); end
    check("r036_fault", bus.align_fault, 1);
    check("r036_aligned", bus.aligned, 0);
    check("r036_offset", bus.align_offset, 0);

    // Relock with the fault still sticky, then resync clears everything.
    lock(2);
    check("r038_fault_held", bus.align_fault, 1);
    rs = 1'b1; w_data(); step(); rs = 1'b0;
    check("r038_fault", bus.align_fault, 0);
    check("r038_offset", bus.align_offset, 0);
    check("r038_aligned", bus.aligned, 0);

    // Broken /K/ run must not reach WAIT_R; only the final full run counts.
    w_data(); step();
    repeat (3) begin w_cgs(); step(); end
    w_data(); step();
    repeat (3) begin w_cgs(); step(); end
    w_r(3); step();
    check("r035_no_lock", bus.aligned, 0);
    repeat (4) begin w_cgs(); step(); end
    w_r(3); step();
    check("r035_lock", bus.aligned, 1);
    check("r035_offset", bus.align_offset, 3);

    // Asynchronous reset between edges while locked.
    repeat (2) begin w_data(); step(); end
    #2 rst_n = 1'b0;
    #1;
    check("arst_out", {bus.out_k, bus.out_data}, 36'h0);
    check("arst_aligned", bus.aligned, 0);
    check("arst_offset", bus.align_offset, 0);
    check("arst_fault", bus.align_fault, 0);
    model_reset();
    #1 rst_n = 1'b1;
    lock(0);
    check("r039_relock", bus.aligned, 1);

    // Fault and resync in the same cycle: resync wins.
    repeat (4) begin w_char(0, 8'h7C); step(); end
    w_data(); step();
    rs = 1'b1; w_data(); step(); rs = 1'b0;
    check("r028_fault", bus.align_fault, 0);
    check("r028_aligned", bus.aligned, 0);

    // Randomized framing.
    repeat (150) begin
      n = $urandom_range(2, 6);
      repeat (n) begin w_cgs(); rand_ctrl(); step(); end
      if ($urandom_range(0, 3) == 0) begin w_data(); rand_ctrl(); step(); end
      w_r($urandom_range(0, 3)); rand_ctrl(); step();
      n = $urandom_range(5, 25);
      repeat (n) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: w_data();
          6, 7, 8: w_char($urandom_range(0, 3), ($urandom_range(0, 1) != 0) ? 8'h7C : 8'hFC);
          default: w_wild();
        endcase
        rand_ctrl();
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
